// File: rtl/param_shift_sequencer.sv
// -----------------------------------------------------------------------------
// param_shift_sequencer
//   WIDTH-bit register with parallel load and a multi-step shift sequencer.
//   In IDLE the register can be loaded (load_n low) or a shift sequence can be
//   started (start high). A started sequence applies one single-bit shift or
//   rotate per clock for 'amount' clocks, then spends one cycle in DONE, which
//   pulses 'done', before returning to IDLE.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous reset, active low
//   load_val   parallel load value (WIDTH bits)
//   load_n     active-low parallel load, honoured only in IDLE
//   start      begin a shift sequence, honoured only in IDLE
//   op         000 LSR, 001 ASR, 010 LSL, 011 ROR, 100 ROL, others HOLD
//   amount     number of single-bit steps, latched on start
//   serial_in  fill bit for LSR (into MSB) and LSL (into LSB), sampled live
//   q          register contents
//   carry      last bit shifted or rotated out
//   busy       high whenever the FSM is not IDLE
//   done       one-cycle pulse when a sequence completes
// -----------------------------------------------------------------------------
module param_shift_sequencer #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] load_val,
   input  logic             load_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [AMT_W-1:0] amount,
   input  logic             serial_in,
   output logic [WIDTH-1:0] q,
   output logic             carry,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [2:0] OP_LSR = 3'b000;
   localparam logic [2:0] OP_ASR = 3'b001;
   localparam logic [2:0] OP_LSL = 3'b010;
   localparam logic [2:0] OP_ROR = 3'b011;
   localparam logic [2:0] OP_ROL = 3'b100;

   logic [1:0]       state;
   logic [2:0]       op_r;     // operation latched on start
   logic [AMT_W-1:0] step_cnt; // steps still to run, loaded with amount on start
   logic [WIDTH-1:0] shift_q;
   logic             shift_c;

   // Result of one step of the latched operation applied to the current q.
   always_comb begin
      // NOTE: every always_comb output gets a default before the case so no
      // path leaves it unassigned, which would otherwise infer a latch.
      shift_q = q;
      shift_c = 1'b0;
      case (op_r)
         OP_LSR: begin
            shift_q = {serial_in, q[WIDTH-1:1]};
            shift_c = q[0];
         end
         OP_ASR: begin
            shift_q = {q[WIDTH-1], q[WIDTH-1:1]};
            shift_c = q[0];
         end
         OP_LSL: begin
            shift_q = {q[WIDTH-2:0], serial_in};
            shift_c = q[WIDTH-1];
         end
         OP_ROR: begin
            shift_q = {q[0], q[WIDTH-1:1]};
            shift_c = q[0];
         end
         OP_ROL: begin
            shift_q = {q[WIDTH-2:0], q[WIDTH-1]};
            shift_c = q[WIDTH-1];
         end
         default: begin
            // HOLD: register unchanged, carry cleared, step still counted.
            shift_q = q;
            shift_c = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; the reset branch is asynchronous, so an
   // in-flight sequence is abandoned immediately and never reaches DONE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         q        <= '0;
         carry    <= 1'b0;
         op_r     <= '0;
         step_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!load_n) begin
                  // Load takes priority; a coincident start is dropped.
                  q     <= load_val;
                  carry <= 1'b0;
               end else if (start) begin
                  op_r     <= op;
                  step_cnt <= amount;
                  carry    <= 1'b0;
                  state    <= (amount == '0) ? DONE : SHIFT;
               end
            end
            SHIFT: begin
               q        <= shift_q;
               carry    <= shift_c;
               step_cnt <= step_cnt - AMT_W'(1);
               if (step_cnt == AMT_W'(1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_param_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_param_shift_sequencer
//   Self-checking bench for param_shift_sequencer (WIDTH=8, AMT_W=4).
//   Each started sequence pushes its expected final q/carry, computed by a
//   bit-level reference model, onto a queue; the entry is popped and compared
//   when the DUT raises done. Handshake timing (busy length, single done
//   pulse) and reset/priority behaviour are checked inline per scenario.
// -----------------------------------------------------------------------------
module tb_param_shift_sequencer;

   localparam int WIDTH = 8;
   localparam int AMT_W = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [WIDTH-1:0] load_val;
   logic             load_n;
   logic             start;
   logic [2:0]       op;
   logic [AMT_W-1:0] amount;
   logic             serial_in;
   logic [WIDTH-1:0] q;
   logic             carry;
   logic             busy;
   logic             done;

   typedef struct packed {
      logic [WIDTH-1:0] q;
      logic             c;
   } exp_t;

   exp_t             sb[$];
   logic [WIDTH-1:0] mq;
   int               errors = 0;
   int               checks = 0;

   always #5 clk = ~clk;

   param_shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .load_val  (load_val),
      .load_n    (load_n),
      .start     (start),
      .op        (op),
      .amount    (amount),
      .serial_in (serial_in),
      .q         (q),
      .carry     (carry),
      .busy      (busy),
      .done      (done)
   );

   // Reference model: apply n single-bit steps of operation o to q0.
   function automatic exp_t model_seq(input logic [WIDTH-1:0] q0, input logic [2:0] o,
                                      input int n, input logic sin);
      exp_t r;
      r.q = q0;
      r.c = 1'b0;
      for (int i = 0; i < n; i++) begin
         case (o)
            3'b000: begin r.c = r.q[0];       r.q = {sin, r.q[WIDTH-1:1]};        end
            3'b001: begin r.c = r.q[0];       r.q = {r.q[WIDTH-1], r.q[WIDTH-1:1]}; end
            3'b010: begin r.c = r.q[WIDTH-1]; r.q = {r.q[WIDTH-2:0], sin};        end
            3'b011: begin r.c = r.q[0];       r.q = {r.q[0], r.q[WIDTH-1:1]};     end
            3'b100: begin r.c = r.q[WIDTH-1]; r.q = {r.q[WIDTH-2:0], r.q[WIDTH-1]}; end
            default: r.c = 1'b0;
         endcase
      end
      return r;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [WIDTH-1:0] v);
      @(negedge clk);
      load_val = v;
      load_n   = 1'b0;
      tick;
      load_n = 1'b1;
      checks++;
      if (q !== v || carry !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL load: q=%h carry=%b busy=%b, expected q=%h carry=0 busy=0",
                  q, carry, busy, v);
      end
      mq = v;
   endtask

   // Start a sequence and follow it to completion. With noise set, load/start
   // and a different op/amount are driven throughout the busy window and must
   // have no effect.
   task automatic run_seq(input string name, input logic [2:0] o, input int n,
                          input logic sin, input bit noise);
      int   busy_cyc;
      int   done_cyc;
      int   cyc;
      bit   seen;
      exp_t e;
      @(negedge clk);
      op        = o;
      amount    = AMT_W'(n);
      serial_in = sin;
      start     = 1'b1;
      sb.push_back(model_seq(mq, o, n, sin));
      tick;  // accepting edge
      if (noise) begin
         load_n   = 1'b0;
         load_val = 8'h5A;
         start    = 1'b1;
         op       = (o == 3'b011) ? 3'b100 : 3'b011;
         amount   = AMT_W'(1);
      end else begin
         start = 1'b0;
      end
      busy_cyc = 0;
      done_cyc = 0;
      seen     = 1'b0;
      e        = '0;
      cyc      = 0;
      while (busy === 1'b1 && cyc < 40) begin
         busy_cyc++;
         if (done === 1'b1) begin
            done_cyc++;
            if (!seen) begin
               seen = 1'b1;
               e    = sb.pop_front();
               checks++;
               if (q !== e.q || carry !== e.c) begin
                  errors++;
                  $display("FAIL %s result: q=%h carry=%b, expected q=%h carry=%b",
                           name, q, carry, e.q, e.c);
               end
            end
         end
         tick;
         cyc++;
      end
      // Back in IDLE (or timed out): release the noise before the next edge.
      load_n = 1'b1;
      start  = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s timeout: busy=%b still high after %0d cycles", name, busy, cyc);
      end
      if (!seen) begin
         e = sb.pop_front();
         $display("FAIL %s done: no done pulse observed", name);
         errors++;
      end
      checks++;
      if (busy_cyc != n + 1 || done_cyc != 1) begin
         errors++;
         $display("FAIL %s handshake: busy cycles=%0d done cycles=%0d, expected %0d and 1",
                  name, busy_cyc, done_cyc, n + 1);
      end
      checks++;
      if (q !== e.q || carry !== e.c) begin
         errors++;
         $display("FAIL %s hold: q=%h carry=%b after idle, expected q=%h carry=%b",
                  name, q, carry, e.q, e.c);
      end
      mq = e.q;
   endtask

   task automatic test_reset;
      reset_n   = 1'b0;
      load_val  = '0;
      load_n    = 1'b1;
      start     = 1'b0;
      op        = '0;
      amount    = '0;
      serial_in = 1'b0;
      #23;
      checks++;
      if (q !== 8'h00 || carry !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset: q=%h carry=%b busy=%b done=%b, expected all zero",
                  q, carry, busy, done);
      end
      @(negedge clk);
      reset_n = 1'b1;
      mq = '0;
   endtask

   task automatic test_reset_mid_sequence;
      bit saw_done;
      do_load(8'hA5);
      @(negedge clk);
      op        = 3'b000;
      amount    = AMT_W'(5);
      serial_in = 1'b0;
      start     = 1'b1;
      tick;
      start = 1'b0;
      tick;
      tick;  // two shifts applied
      checks++;
      if (q !== 8'h29 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_seq: q=%h busy=%b after 2 shifts, expected q=29 busy=1", q, busy);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (q !== 8'h00 || carry !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: q=%h carry=%b busy=%b done=%b, expected all zero",
                  q, carry, busy, done);
      end
      saw_done = 1'b0;
      tick;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL abort: done/busy seen after reset, expected both to stay 0");
      end
      mq = '0;
   endtask

   task automatic test_asr;
      do_load(8'h80);
      run_seq("asr3", 3'b001, 3, 1'b0, 1'b0);
      checks++;
      if (q !== 8'hF0 || carry !== 1'b0) begin
         errors++;
         $display("FAIL asr3_value: q=%h carry=%b, expected q=f0 carry=0", q, carry);
      end
      run_seq("asr15", 3'b001, 15, 1'b0, 1'b0);
      checks++;
      if (q !== 8'hFF) begin
         errors++;
         $display("FAIL asr15_value: q=%h, expected ff", q);
      end
   endtask

   task automatic test_rotate;
      do_load(8'h81);
      run_seq("rol1", 3'b100, 1, 1'b0, 1'b0);
      checks++;
      if (q !== 8'h03 || carry !== 1'b1) begin
         errors++;
         $display("FAIL rol1_value: q=%h carry=%b, expected q=03 carry=1", q, carry);
      end
      do_load(8'h81);
      run_seq("ror8", 3'b011, 8, 1'b0, 1'b0);
      checks++;
      if (q !== 8'h81 || carry !== 1'b1) begin
         errors++;
         $display("FAIL ror8_value: q=%h carry=%b, expected q=81 carry=1", q, carry);
      end
   endtask

   task automatic test_logical;
      do_load(8'h0F);
      run_seq("lsl2", 3'b010, 2, 1'b1, 1'b0);
      checks++;
      if (q !== 8'h3F || carry !== 1'b0) begin
         errors++;
         $display("FAIL lsl2_value: q=%h carry=%b, expected q=3f carry=0", q, carry);
      end
      run_seq("lsr4", 3'b000, 4, 1'b0, 1'b0);
      checks++;
      if (q !== 8'h03 || carry !== 1'b1) begin
         errors++;
         $display("FAIL lsr4_value: q=%h carry=%b, expected q=03 carry=1", q, carry);
      end
   endtask

   task automatic test_commands;
      @(negedge clk);
      load_val = 8'h3C;
      load_n   = 1'b0;
      start    = 1'b1;
      op       = 3'b000;
      amount   = AMT_W'(3);
      tick;
      load_n = 1'b1;
      start  = 1'b0;
      checks++;
      if (q !== 8'h3C || busy !== 1'b0) begin
         errors++;
         $display("FAIL load_beats_start: q=%h busy=%b, expected q=3c busy=0", q, busy);
      end
      tick;
      checks++;
      if (q !== 8'h3C || busy !== 1'b0) begin
         errors++;
         $display("FAIL start_dropped: q=%h busy=%b, expected q=3c busy=0", q, busy);
      end
      mq = 8'h3C;
      run_seq("noise_lsl", 3'b010, 3, 1'b1, 1'b1);
      run_seq("noise_ror", 3'b011, 5, 1'b0, 1'b1);
      run_seq("noise_zero", 3'b000, 0, 1'b0, 1'b1);
   endtask

   task automatic test_zero_and_hold;
      do_load(8'hC3);
      run_seq("zero", 3'b010, 0, 1'b1, 1'b0);
      checks++;
      if (q !== 8'hC3) begin
         errors++;
         $display("FAIL zero_value: q=%h, expected c3", q);
      end
      run_seq("rol_carry", 3'b100, 1, 1'b0, 1'b0);  // leaves carry=1
      run_seq("hold3", 3'b110, 3, 1'b1, 1'b0);
      checks++;
      if (q !== 8'h87 || carry !== 1'b0) begin
         errors++;
         $display("FAIL hold3_value: q=%h carry=%b, expected q=87 carry=0", q, carry);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 10; i++) begin
         do_load(WIDTH'($urandom));
         run_seq("random", 3'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                 1'($urandom), 1'b0);
      end
   endtask

   initial begin
      test_reset;
      test_reset_mid_sequence;
      test_asr;
      test_rotate;
      test_logical;
      test_commands;
      test_zero_and_hold;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
